// File: rtl/small_filt_pkg.sv
// Shared constants and helpers for the small filter chain (SmallLpf and small_decim).
// Latency: none (types/functions only); backpressure: n/a.
package small_filt_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_LOG2  = 5;
    localparam int DEF_LOG2_BITS = 3;

    // Accumulator width that holds 2^max_log2 full-scale samples without wrapping.
    function automatic int acc_width(input int width, input int max_log2);
        return width + max_log2;
    endfunction

    function automatic int clamp_log2(input int k, input int max_log2);
        return (k > max_log2) ? max_log2 : k;
    endfunction

endpackage

// File: rtl/small_decim_if.sv
// Sample-in / decimated-out stream bundle for small_decim.
// slave = the decimator side, master = the producer/consumer side.
interface small_decim_if #(
    parameter int WIDTH     = 8,
    parameter int LOG2_BITS = 3
);
    logic                    en;
    logic signed [WIDTH-1:0] data_in;
    logic [LOG2_BITS-1:0]    decim_log2;
    logic signed [WIDTH-1:0] data_out;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  en, data_in, decim_log2, out_ready,
        output data_out, out_valid
    );

    modport master (
        output en, data_in, decim_log2, out_ready,
        input  data_out, out_valid
    );
endinterface

// File: rtl/small_fifo2.sv
// Generic 2-entry FIFO with a registered head; push/pop take effect on the same edge.
// Push while full is accepted only if a pop happens in the same cycle; head holds when drained.
module small_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [1:0]       count;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign head    = head_q;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) head_q <= push_dat;
                    else               tail_q <= push_dat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Draining the last entry leaves head_q as-is so the output keeps its value.
                    if (count == 2'd2) head_q <= tail_q;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_q <= push_dat;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/small_decim.sv
// Accumulate-and-dump 2^k decimator with round-half-up; block result is visible 1 clk after the dump.
// Results queue in a 2-entry buffer; a result arriving at a full, non-draining buffer is dropped (sticky overflow).
module small_decim
    import small_filt_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_LOG2  = DEF_MAX_LOG2,
    parameter int LOG2_BITS = DEF_LOG2_BITS
) (
    input  logic            clk,
    input  logic            rst,
    small_decim_if.slave    io,
    output logic            overflow
);

    localparam int ACC_W = acc_width(WIDTH, MAX_LOG2);

    logic [MAX_LOG2-1:0]     cnt;
    logic [MAX_LOG2-1:0]     last_cnt;
    logic [LOG2_BITS-1:0]    k_lat;
    logic [LOG2_BITS-1:0]    k_cur;
    logic                    block_start;
    logic                    dump;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] rounded;
    logic [WIDTH-1:0]        res;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic [WIDTH-1:0]        fifo_head;

    assign block_start = (cnt == '0);

    always_comb begin
        k_cur      = k_lat;
        last_cnt   = '0;
        sample_ext = '0;
        sum        = '0;
        rnd        = '0;
        rounded    = '0;
        res        = '0;
        dump       = 1'b0;

        // k is taken from the port only on the first sample of a block, then held.
        if (block_start)
            k_cur = LOG2_BITS'(clamp_log2(int'(io.decim_log2), MAX_LOG2));

        last_cnt   = ~({MAX_LOG2{1'b1}} << k_cur);
        sample_ext = {{MAX_LOG2{io.data_in[WIDTH-1]}}, io.data_in};
        sum        = block_start ? sample_ext : (acc + sample_ext);

        if (k_cur != '0)
            rnd = ACC_W'(1) << (k_cur - LOG2_BITS'(1));

        // The mean of WIDTH-bit samples always fits back into WIDTH bits.
        rounded = (sum + rnd) >>> k_cur;
        res     = rounded[WIDTH-1:0];
        dump    = io.en && (cnt == last_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            k_lat    <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            if (io.en) begin
                acc <= sum;
                cnt <= dump ? '0 : (cnt + MAX_LOG2'(1));
                if (block_start)
                    k_lat <= k_cur;
            end
            if (dump && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    assign pop = !fifo_empty && io.out_ready;

    small_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (dump),
        .push_dat (res),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign io.out_valid = !fifo_empty;
    assign io.data_out  = fifo_head;

endmodule
